// File: rtl/vector_sequencer_if.sv
// Command channel into the vector sequencer: valid/ready handshake plus the
// opcode, X/Y words and draw exponent that travel with each command.
interface vector_sequencer_if #(
    parameter int DV_W = 12
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [DV_W-1:0] cmd_x;
    logic [DV_W-1:0] cmd_y;
    logic [3:0]      cmd_scale;

    modport master (output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_scale,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_scale,
                    output cmd_ready);
endinterface

// File: rtl/vector_sequencer.sv
// Sequencer for the X/Y position counters: loads positions via haltstrobe and
// times each draw as 2^s clocks of go, followed by a go-low settle window.
module vector_sequencer #(
    parameter int DV_W       = 12,
    parameter int MAX_SCALE  = 10,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_sequencer_if.slave      cmd,
    input  logic                   abort,
    input  logic                   restart,
    output logic [DV_W-1:0]        dv_x,
    output logic [DV_W-1:0]        dv_y,
    output logic                   haltstrobe,
    output logic                   timer0,
    output logic                   go,
    output logic                   busy,
    output logic                   halted
);
    localparam int TMR_W = MAX_SCALE + 1;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DRAW = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAW,
        ST_SETTLE,
        ST_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DV_W-1:0]   dv_x_q, dv_x_d;
    logic [DV_W-1:0]   dv_y_q, dv_y_d;
    logic              go_q, go_d;
    logic              hs_q, hs_d;
    logic              t0_q, t0_d;

    // Timer preload for a draw: 2^s - 1 so that go stays high for 2^s clocks.
    function automatic logic [TMR_W-1:0] draw_len(input logic [3:0] sc);
        int s;
        s = (int'(sc) > MAX_SCALE) ? MAX_SCALE : int'(sc);
        return TMR_W'((64'd1 << s) - 64'd1);
    endfunction

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted        = (state_q == ST_HALTED);
    assign dv_x          = dv_x_q;
    assign dv_y          = dv_y_q;
    assign go            = go_q;
    assign haltstrobe    = hs_q;
    assign timer0        = t0_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dv_x_d  = dv_x_q;
        dv_y_d  = dv_y_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    case (cmd.cmd_op)
                        OP_LOAD: begin
                            dv_x_d  = cmd.cmd_x;
                            dv_y_d  = cmd.cmd_y;
                            state_d = ST_LOAD;
                        end
                        OP_DRAW: begin
                            dv_x_d  = cmd.cmd_x;
                            dv_y_d  = cmd.cmd_y;
                            timer_d = draw_len(cmd.cmd_scale);
                            state_d = ST_DRAW;
                        end
                        OP_HALT: state_d = ST_HALTED;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_DRAW: begin
                // The settle window reuses the draw timer as its down-counter.
                if ((timer_q == '0) || abort) begin
                    timer_d = TMR_W'(SETTLE_CYC - 1);
                    state_d = ST_SETTLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_HALTED: if (restart) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        go_d = (state_d == ST_DRAW);
        hs_d = (state_d == ST_LOAD);
        t0_d = (state_d == ST_DRAW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            dv_x_q  <= '0;
            dv_y_q  <= '0;
            go_q    <= 1'b0;
            hs_q    <= 1'b0;
            t0_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dv_x_q  <= dv_x_d;
            dv_y_q  <= dv_y_d;
            go_q    <= go_d;
            hs_q    <= hs_d;
            t0_q    <= t0_d;
        end
    end
endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: reset, LOAD, timed and aborted DRAWs,
// HALT/restart with a held command, async reset mid-draw and a command stream.
module tb_vector_sequencer;
    localparam int DV_W = 12;

    logic            clk;
    logic            rst_n;
    logic            abort;
    logic            restart;
    logic [DV_W-1:0] dv_x;
    logic [DV_W-1:0] dv_y;
    logic            haltstrobe;
    logic            timer0;
    logic            go;
    logic            busy;
    logic            halted;

    int errors;
    int checks;
    int cyc;
    int acc_cyc;
    int overlap_cnt;
    int t0_err_cnt;

    vector_sequencer_if #(.DV_W(DV_W)) cif ();

    vector_sequencer #(.DV_W(DV_W), .MAX_SCALE(10), .SETTLE_CYC(2)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .cmd        (cif),
        .abort      (abort),
        .restart    (restart),
        .dv_x       (dv_x),
        .dv_y       (dv_y),
        .haltstrobe (haltstrobe),
        .timer0     (timer0),
        .go         (go),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (go && haltstrobe) overlap_cnt <= overlap_cnt + 1;
            if (timer0 != go)     t0_err_cnt  <= t0_err_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command and hold it until the edge that consumes it.
    task automatic issue(input logic [1:0] op, input logic [DV_W-1:0] x,
                         input logic [DV_W-1:0] y, input logic [3:0] sc);
        int n;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_x     = x;
        cif.cmd_y     = y;
        cif.cmd_scale = sc;
        n = 0;
        forever begin
            @(negedge clk);
            if (cif.cmd_ready) break;
            n++;
            if (n > 3000) begin
                check_val("issue_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc       = cyc;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
    endtask

    task automatic count_go(input int abort_at, output int n, output int t0n);
        n   = 0;
        t0n = 0;
        forever begin
            @(negedge clk);
            if (!go) break;
            n++;
            if (timer0) t0n++;
            if (abort_at > 0 && n == abort_at) abort = 1'b1;
            if (n > 3000) begin
                check_val("go_timeout", 32'd0, 32'd1);
                break;
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        int n, t0n, a0, a1, a2;
        errors = 0; checks = 0; cyc = 0; acc_cyc = 0;
        overlap_cnt = 0; t0_err_cnt = 0;
        rst_n = 1'b0; abort = 1'b0; restart = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_op = 2'b00;
        cif.cmd_x = '0; cif.cmd_y = '0; cif.cmd_scale = 4'd0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready",  32'(cif.cmd_ready), 32'd1);
        check_val("rst_go",     32'(go),            32'd0);
        check_val("rst_hs",     32'(haltstrobe),    32'd0);
        check_val("rst_t0",     32'(timer0),        32'd0);
        check_val("rst_dvx",    32'(dv_x),          32'd0);
        check_val("rst_dvy",    32'(dv_y),          32'd0);
        check_val("rst_busy",   32'(busy),          32'd0);
        check_val("rst_halted", 32'(halted),        32'd0);

        // LOAD: one clock of haltstrobe with the new position on the dv buses
        issue(2'b01, 12'h123, 12'h456, 4'd0);
        @(negedge clk);
        check_val("load_dvx",   32'(dv_x),          32'h123);
        check_val("load_dvy",   32'(dv_y),          32'h456);
        check_val("load_hs",    32'(haltstrobe),    32'd1);
        check_val("load_t0",    32'(timer0),        32'd0);
        check_val("load_go",    32'(go),            32'd0);
        check_val("load_ready", 32'(cif.cmd_ready), 32'd0);
        @(negedge clk);
        check_val("load_hs_end",    32'(haltstrobe),    32'd0);
        check_val("load_ready_end", 32'(cif.cmd_ready), 32'd1);

        // DRAW scale 3: 8 go clocks, then 2 settle clocks
        issue(2'b10, 12'h010, 12'h020, 4'd3);
        count_go(0, n, t0n);
        check_val("draw3_go",     32'(n),             32'd8);
        check_val("draw3_t0",     32'(t0n),           32'd8);
        check_val("draw3_dvx",    32'(dv_x),          32'h010);
        check_val("draw3_s1_rdy", 32'(cif.cmd_ready), 32'd0);
        check_val("draw3_s1_bsy", 32'(busy),          32'd1);
        @(negedge clk);
        check_val("draw3_s2_rdy", 32'(cif.cmd_ready), 32'd0);
        check_val("draw3_s2_go",  32'(go),            32'd0);
        @(negedge clk);
        check_val("draw3_idle",   32'(cif.cmd_ready), 32'd1);

        // DRAW scale 15 clamps to 2^10
        issue(2'b10, 12'h7FF, 12'h800, 4'd15);
        count_go(0, n, t0n);
        check_val("draw15_go",  32'(n),    32'd1024);
        check_val("draw15_t0",  32'(t0n),  32'd1024);
        check_val("draw15_dvy", 32'(dv_y), 32'h800);

        // DRAW scale 10 aborted on the 5th go clock
        issue(2'b10, 12'hAAA, 12'h555, 4'd10);
        count_go(5, n, t0n);
        check_val("abort5_go",   32'(n),             32'd5);
        check_val("abort5_s1",   32'(cif.cmd_ready), 32'd0);
        @(negedge clk);
        check_val("abort5_s2",   32'(cif.cmd_ready), 32'd0);
        @(negedge clk);
        check_val("abort5_idle", 32'(cif.cmd_ready), 32'd1);

        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        check_val("abort_idle_rdy",  32'(cif.cmd_ready), 32'd1);
        check_val("abort_idle_busy", 32'(busy),          32'd0);
        abort = 1'b0;

        // abort held from before accept still yields one go clock
        abort = 1'b1;
        issue(2'b10, 12'h0F0, 12'h00F, 4'd4);
        count_go(0, n, t0n);
        check_val("abort1_go", 32'(n), 32'd1);

        // HALT with a LOAD held upstream
        issue(2'b11, 12'h000, 12'h000, 4'd0);
        @(negedge clk);
        check_val("halt_halted", 32'(halted),        32'd1);
        check_val("halt_ready",  32'(cif.cmd_ready), 32'd0);
        check_val("halt_busy",   32'(busy),          32'd0);
        cif.cmd_valid = 1'b1; cif.cmd_op = 2'b01;
        cif.cmd_x = 12'hABC; cif.cmd_y = 12'hDEF;
        repeat (3) @(negedge clk);
        check_val("halt_hold_dvx", 32'(dv_x),   32'h0F0);
        check_val("halt_hold_hs",  32'(haltstrobe), 32'd0);
        check_val("halt_still",    32'(halted), 32'd1);
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        @(negedge clk);
        check_val("restart_ready",  32'(cif.cmd_ready), 32'd1);
        check_val("restart_halted", 32'(halted),        32'd0);
        check_val("restart_dvx",    32'(dv_x),          32'h0F0);
        @(posedge clk); #1 cif.cmd_valid = 1'b0; cif.cmd_op = 2'b00;
        @(negedge clk);
        check_val("held_load_dvx", 32'(dv_x),       32'hABC);
        check_val("held_load_dvy", 32'(dv_y),       32'hDEF);
        check_val("held_load_hs",  32'(haltstrobe), 32'd1);

        // async reset between edges during a DRAW
        issue(2'b10, 12'h321, 12'h654, 4'd8);
        repeat (3) @(negedge clk);
        check_val("pre_rst_go", 32'(go), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_go",    32'(go),            32'd0);
        check_val("async_t0",    32'(timer0),        32'd0);
        check_val("async_ready", 32'(cif.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_dvx",   32'(dv_x),          32'd0);
        check_val("post_rst_dvy",   32'(dv_y),          32'd0);
        check_val("post_rst_ready", 32'(cif.cmd_ready), 32'd1);
        check_val("post_rst_go",    32'(go),            32'd0);

        // back-to-back stream with throughput checks
        issue(2'b01, 12'h111, 12'h222, 4'd0);
        a0 = acc_cyc;
        issue(2'b10, 12'h333, 12'h444, 4'd2);
        a1 = acc_cyc;
        @(negedge clk);
        check_val("stream_draw_dvx", 32'(dv_x), 32'h333);
        check_val("stream_draw_go",  32'(go),   32'd1);
        issue(2'b01, 12'h555, 12'h666, 4'd0);
        a2 = acc_cyc;
        check_val("tput_load", 32'(a1 - a0), 32'd2);
        check_val("tput_draw", 32'(a2 - a1), 32'd7);
        @(negedge clk);
        check_val("stream_load_dvx", 32'(dv_x),       32'h555);
        check_val("stream_load_hs",  32'(haltstrobe), 32'd1);
        repeat (3) @(negedge clk);
        check_val("no_overlap",  32'(overlap_cnt), 32'd0);
        check_val("t0_tracks_go", 32'(t0_err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
